vector_pack_feeder: RTL
=======================

// Module: vector_pack_feeder
// PURPOSE
//  Upstream feeder for the pipelined vector-max unit: accepts a serial stream of signed
//  elements over a valid/ready handshake, packs them into LANES-wide vectors and issues
//  each vector with a valid strobe. Partial vectors closed by s_last are padded with
//  PAD_VALUE (most negative code) so the downstream max is unaffected. Two-deep buffering
//  (fill buffer + output register) sustains one element per cycle when m_ready=1.
// PARAMETERS
//  LANES      8     elements per vector (>=2)
//  WIDTH      8     element width, signed two's complement
//  PAD_VALUE  -128  value written to unused lanes of a partial vector (WIDTH-bit)
// PORTS
//  clk      in   1              rising-edge clock
//  rst      in   1              synchronous, active-high reset
//  s_valid  in   1              input element valid
//  s_ready  out  1              feeder can accept an element this cycle
//  s_data   in   WIDTH          signed input element
//  s_last   in   1              element closes the current vector (may be partial)
//  m_valid  out  1              output vector valid; feeds valid_in of the max unit
//  m_ready  in   1              downstream accepts; tie 1 when driving the max unit
//  m_vec    out  LANES*WIDTH    lane i at [i*WIDTH +: WIDTH]; lane 0 = first element
//  m_count  out  $clog2(LANES+1) number of real (non-pad) lanes, 1..LANES
//  m_last   out  1              vector was closed by s_last
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): m_valid=0, m_vec=0, m_count=0, m_last=0, fill pointer=0,
//    state FILL, s_ready=1 the cycle after; any partial or held vector is discarded.
//  - Accept when s_valid&&s_ready: s_data written to lane fill_ptr, fill_ptr++.
//  - Vector completes on accept with fill_ptr==LANES-1 or s_last=1; lanes above the
//    written one take PAD_VALUE; count = fill_ptr+1; last = s_last.
//  - Completed vector moves to output register at the same edge if output is free
//    (m_valid=0 or m_ready=1); else held in fill buffer, state -> PENDING.
//  - FSM: FILL (s_ready=1) -> PENDING on completion with output blocked.
//    PENDING (s_ready=0) -> FILL when output frees; pending vector loads output at that
//    edge, fill_ptr=0, s_ready=1 from the next cycle.
//  - s_ready is a function of state only (no combinational path from m_ready).
//  - Latency: completing accept at edge N -> m_valid=1 after edge N (visible cycle N+1).
//  - Output handshake: m_vec/m_count/m_last stable while m_valid&&!m_ready; m_valid
//    drops after a transfer unless a new vector loads at the same edge (back-to-back).
//  - s_last on the LANES-th element: one full vector, count=LANES, last=1, no empty vector.
//  - s_last never produces an empty vector; s_valid=0 cycles leave state unchanged.
//  - fill_ptr wraps to 0 on every completion; no arithmetic on data, values pass unmodified.
// STRUCTURE
//  - Package vector_pack_pkg: LANES, WIDTH, PAD_VALUE, CNT_W=$clog2(LANES+1),
//    state enum {FILL, PENDING}.
//  - One sub-module: vector_pack_outreg (output holding register, load/hold/clear on
//    valid/ready); fill buffer, pointer and FSM live in the top.
// TESTING
//  1. m_ready=1, elements 1..8 consecutive -> cycle after 8th: m_valid=1, lanes 1..8,
//     m_count=8, m_last=0; single-cycle pulse.
//  2. Elements 5,-2,7 with s_last on 7 -> lanes 5,-2,7,-128 x5, m_count=3, m_last=1.
//  3. m_ready=1, 16 elements continuous -> two pulses 8 cycles apart, s_ready never 0.
//  4. m_ready=0, 16 elements -> vector A held, s_ready=0 after 16th accept; raise m_ready
//     -> A transfers, B presented next cycle, s_ready=1 one cycle after B loads.
//  5. rst after 4 elements -> m_valid=0, s_ready=1; next 8 elements 10..17 give a clean
//     vector 10..17, count 8, none of the first 4 values appear.
//  6. s_last on 8th element -> exactly one vector, m_count=8, m_last=1, no extra pulse.

Source files
------------

// File: rtl/vector_pack_pkg.sv
// Shared constants and types for the vector packing feeder.
// PAD_VALUE is the most negative code, so padded lanes never win a downstream max.
package vector_pack_pkg;

    localparam int LANES = 8;
    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(LANES + 1);

    localparam logic signed [WIDTH-1:0] PAD_VALUE = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        FILL,
        PENDING
    } state_t;

endpackage

// File: rtl/vector_pack_outreg.sv
// Output holding register for packed vectors.
// It loads on load, holds while stalled and drops valid once the vector transfers.
module vector_pack_outreg
    import vector_pack_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [LANES*WIDTH-1:0] load_vec,
    input  logic [CNT_W-1:0]       load_count,
    input  logic                   load_last,
    input  logic                   m_ready,
    output logic                   m_valid,
    output logic [LANES*WIDTH-1:0] m_vec,
    output logic [CNT_W-1:0]       m_count,
    output logic                   m_last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_vec   <= '0;
            m_count <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_vec   <= load_vec;
            m_count <= load_count;
            m_last  <= load_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/vector_pack_feeder.sv
// Packs a serial stream of signed elements into LANES-wide vectors.
// The fill buffer plus output register allow one element per cycle without a ready loop.
module vector_pack_feeder
    import vector_pack_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [LANES*WIDTH-1:0]  m_vec,
    output logic [CNT_W-1:0]        m_count,
    output logic                    m_last
);

    localparam int PTR_W = $clog2(LANES);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LANES - 1);

    state_t                 state;
    logic [PTR_W-1:0]       fill_ptr;
    logic [LANES*WIDTH-1:0] fill_buf;
    logic [CNT_W-1:0]       pend_count;
    logic                   pend_last;

    logic                   accept;
    logic                   complete;
    logic                   out_free;
    logic                   load;
    logic [LANES*WIDTH-1:0] new_vec;
    logic [CNT_W-1:0]       new_count;
    logic [LANES*WIDTH-1:0] load_vec;
    logic [CNT_W-1:0]       load_count;
    logic                   load_last;

    assign s_ready   = (state == FILL);
    assign accept    = s_valid && s_ready;
    assign complete  = accept && ((fill_ptr == LAST_PTR) || s_last);
    assign out_free  = !m_valid || m_ready;
    assign new_count = CNT_W'(fill_ptr) + CNT_W'(1);

    // Lanes already written keep their value; the incoming element lands at fill_ptr
    // and everything above it is padded in case this element closes the vector.
    always_comb begin
        new_vec = fill_buf;
        for (int i = 0; i < LANES; i++) begin
            if (i == int'(fill_ptr)) begin
                new_vec[i*WIDTH +: WIDTH] = s_data;
            end else if (i > int'(fill_ptr)) begin
                new_vec[i*WIDTH +: WIDTH] = PAD_VALUE;
            end
        end
    end

    always_comb begin
        load       = (state == PENDING) ? out_free   : (complete && out_free);
        load_vec   = (state == PENDING) ? fill_buf   : new_vec;
        load_count = (state == PENDING) ? pend_count : new_count;
        load_last  = (state == PENDING) ? pend_last  : s_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            fill_ptr   <= '0;
            pend_count <= '0;
            pend_last  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (complete) begin
                        fill_ptr   <= '0;
                        pend_count <= new_count;
                        pend_last  <= s_last;
                        if (!out_free) begin
                            state <= PENDING;
                        end
                    end else if (accept) begin
                        fill_ptr <= fill_ptr + PTR_W'(1);
                    end
                end
                PENDING: begin
                    if (out_free) begin
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // A completed vector stays padded in the buffer, ready to be replayed from PENDING.
    always_ff @(posedge clk) begin
        if (accept) begin
            fill_buf <= new_vec;
        end
    end

    vector_pack_outreg u_outreg (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_vec   (load_vec),
        .load_count (load_count),
        .load_last  (load_last),
        .m_ready    (m_ready),
        .m_valid    (m_valid),
        .m_vec      (m_vec),
        .m_count    (m_count),
        .m_last     (m_last)
    );

endmodule
